// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
//   Shared ALU definitions used by the issue controller and its result FIFO:
//   data/opcode widths, the ALU opcode set and the legal-opcode predicate.
//   No ports (package).
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int OPCODE_SIZE = 4;

    typedef enum logic [OPCODE_SIZE-1:0] {
        OP_NOT  = 4'd0,
        OP_AND  = 4'd1,
        OP_ANDI = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_ADD  = 4'd5,
        OP_ADDI = 4'd6,
        OP_SUB  = 4'd7,
        OP_COMP = 4'd8,
        OP_LT   = 4'd9,
        OP_EQ   = 4'd10
    } alu_op_e;

    // True for opcodes the ALU implements; encodings 11..15 are unused.
    function automatic logic is_legal_opcode(input logic [OPCODE_SIZE-1:0] op);
        logic legal;
        case (op)
            OP_NOT, OP_AND, OP_ANDI, OP_OR, OP_XOR, OP_ADD,
            OP_ADDI, OP_SUB, OP_COMP, OP_LT, OP_EQ: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
//   In-order result queue, DEPTH entries of WIDTH bits, synchronous push/pop
//   with asynchronous active-low reset of the pointers and count.
// Ports:
//   clock, reset_n   clock, async active-low reset
//   push, push_entry write an entry (never while full)
//   pop              remove the head entry (only while valid)
//   valid            FIFO not empty
//   head             head entry; all-zero while empty
//   count            number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_entry,
    input  logic                       pop,
    output logic                       valid,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the head is forced to zero while
    // empty, so stale contents are never visible after reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign valid = (count != '0);
    assign head  = valid ? mem[rd_ptr] : '0;

    no_push_when_full: assert property (
        @(posedge clock) disable iff (!reset_n)
        !(push && (count == (PTR_W+1)'(DEPTH)))
    );

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Initiator side of the ALU interface. Accepts tagged ops on a valid/ready
//   channel, drives registered opcode/operands/enable to the ALU, captures the
//   ALU's registered result two edges later and returns results in order on a
//   tagged valid/ready channel through a credit-managed result FIFO.
// Ports:
//   clock, reset_n                       clock, async active-low reset
//   in_valid/in_ready                    op request handshake
//   in_opcode/in_op1/in_op2/in_tag       op payload; tag is returned unchanged
//   alu_enable/alu_opcode/alu_input1/2   registered ALU drive
//   alu_result                           ALU output, one edge after enable
//   res_valid/res_ready                  result handshake
//   res_data/res_tag/res_err             result payload (FIFO head)
// Configuration:
//   ALU_ILLEGAL_TRAP_EN  when defined, unknown opcodes bypass the ALU and
//                        return data 0 with res_err=1; otherwise res_err is 0.
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int RES_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPCODE_SIZE-1:0] in_opcode,
    input  logic [WORD_SIZE-1:0]   in_op1,
    input  logic [WORD_SIZE-1:0]   in_op2,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   alu_enable,
    output logic [OPCODE_SIZE-1:0] alu_opcode,
    output logic [WORD_SIZE-1:0]   alu_input1,
    output logic [WORD_SIZE-1:0]   alu_input2,
    input  logic [WORD_SIZE-1:0]   alu_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WORD_SIZE-1:0]   res_data,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_err
);
    localparam int CNT_W   = $clog2(RES_DEPTH) + 1;
    localparam int OCC_W   = CNT_W + 1;
    localparam int ENTRY_W = 1 + TAG_W + WORD_SIZE;

    logic                 accept;
    logic                 in_illegal;
    logic                 res_pop;
    logic                 s1_valid, s1_err;
    logic                 s2_valid, s2_err;
    logic [TAG_W-1:0]     s1_tag, s2_tag;
    logic [CNT_W-1:0]     fifo_count;
    logic [OCC_W-1:0]     occ_next;
    logic [WORD_SIZE-1:0] push_data;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head_entry;

    assign accept  = in_valid & in_ready;
    assign res_pop = res_valid & res_ready;

    // NOTE: default assigned first so no path leaves the signal unassigned
    // (which would infer a latch).
    always_comb begin
        in_illegal = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
        in_illegal = !is_legal_opcode(in_opcode);
`endif
    end

    // Credits in use after this edge: every accepted op holds a slot from
    // acceptance until it is popped, whether in s1, s2 or the FIFO. in_ready
    // is registered from that value, so res_ready never reaches it
    // combinationally and it reads 0 during reset.
    assign occ_next = OCC_W'(fifo_count) + OCC_W'(s1_valid) + OCC_W'(s2_valid)
                    + OCC_W'(accept) - OCC_W'(res_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready   <= 1'b0;
            alu_enable <= 1'b0;
            alu_opcode <= '0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            s1_valid   <= 1'b0;
            s1_err     <= 1'b0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_err     <= 1'b0;
            s2_tag     <= '0;
        end else begin
            in_ready   <= (occ_next < OCC_W'(RES_DEPTH));
            // Trapped slots never start the ALU but still walk the pipeline
            // so they come back in order with the same latency.
            alu_enable <= accept & ~in_illegal;
            if (accept) begin
                alu_opcode <= in_opcode;
                alu_input1 <= in_op1;
                alu_input2 <= in_op2;
                s1_tag     <= in_tag;
                s1_err     <= in_illegal;
            end
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s2_tag   <= s1_tag;
            s2_err   <= s1_err;
        end
    end

    assign push_data  = s2_err ? '0 : alu_result;
    assign push_entry = {s2_err, s2_tag, push_data};

    alu_result_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_result_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (s2_valid),
        .push_entry (push_entry),
        .pop        (res_pop),
        .valid      (res_valid),
        .head       (head_entry),
        .count      (fifo_count)
    );

    assign {res_err, res_tag, res_data} = head_entry;

endmodule
